// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - serial-to-parallel deserializer with one-hot write decoder
// Optional feature macro: DESER_FLUSH_EN (adds flush input that closes a partial word)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_bit     serial data bit; in_valid qualifies it; in_ready high while filling
//   out_data   assembled word, bit i = i-th accepted bit (LSB first)
//   out_valid  word complete and stable; out_ready takes it
//   flush      (DESER_FLUSH_EN only) close a partially filled word
module demux_deser #(
    parameter int n = 4,
    localparam int m = 2 ** n
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [m-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef DESER_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [n-1:0] idx;
    logic         accept;
    logic         last_bit;
    logic         close_word;
    logic         handoff;
    logic [m-1:0] wr_en;
    logic [m-1:0] data_next;

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);

    assign accept   = in_valid & in_ready;
    assign last_bit = &idx;
    assign handoff  = out_valid & out_ready;

`ifdef DESER_FLUSH_EN
    // A flush closes the word only if it holds at least one bit, counting a
    // bit accepted in the same cycle (that bit lands before the word closes).
    assign close_word = (accept & last_bit) |
                        (in_ready & flush & ((idx != '0) | accept));
`else
    assign close_word = accept & last_bit;
`endif

    // Structural demux: one-hot decode of idx gated by accept steers in_bit
    // into exactly one word bit; every other bit recirculates.
    for (genvar i = 0; i < m; i++) begin : g_dec
        assign wr_en[i]     = accept & (idx == n'(i));
        assign data_next[i] = wr_en[i] ? in_bit : out_data[i];
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (close_word) state_next = HOLD;
            HOLD:    if (out_ready)  state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            idx      <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            if (close_word) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
            // Clearing on handoff means a short (flushed) word always has
            // zeros in its unwritten positions.
            if (handoff) begin
                out_data <= '0;
            end else begin
                out_data <= data_next;
            end
        end
    end

endmodule

// File: tb/tb_demux_deser.sv
// tb/tb_demux_deser.sv - directed self-checking bench for demux_deser (n=2 and n=4)
module tb_demux_deser;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;

    logic        w_bit;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic        w_out_valid;
    logic        w_out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_deser #(.n(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DESER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    demux_deser #(.n(4)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (w_bit),
        .in_valid  (w_valid),
        .in_ready  (w_ready),
        .out_data  (w_data),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready)
`ifdef DESER_FLUSH_EN
        ,
        .flush     (1'b0)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_data: got %b expected 0000", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (w_data !== 16'h0000) begin errors++; $display("FAIL reset_data16: got %h expected 0000", w_data); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] bits;
        bits = 4'b1101;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_bit   = bits[i];
            in_valid = 1'b1;
            step();
            if (i < 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid%0d: got %b expected 0", i, out_valid); end
            end
        end
        checks++; if (out_data !== 4'b1101) begin errors++; $display("FAIL b2b_data: got %b expected 1101", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
        in_bit = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_one_cycle: got %b expected 0", out_valid); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL b2b_no_passthrough: got %b expected 0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            feed(bits[i]);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    in_bit = ~bits[i];
                    step();
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid%0d_%0d: got %b expected 0", i, g, out_valid); end
                end
            end
        end
        checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL gap_data: got %b expected 0110", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
        drain();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) feed(1'b1);
        in_bit   = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (out_data !== 4'b1111) begin errors++; $display("FAIL hold_data%0d: got %b expected 1111", c, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d: got %b expected 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b expected 1", c, out_valid); end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL hold_cleared: got %b expected 0000", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_released: got %b expected 0", out_valid); end
        feed(1'b1);
        checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL hold_restart_idx0: got %b expected 0001", out_data); end
    endtask

    task automatic test_mid_reset();
        feed(1'b1);
        feed(1'b1);
        #2;
        reset = 1'b1;
        #2;
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL rst_data: got %b expected 0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            feed(1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_early_valid%0d: got %b expected 0", i, out_valid); end
        end
        feed(1'b1);
        checks++; if (out_data !== 4'b1000) begin errors++; $display("FAIL rst_word: got %b expected 1000", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_word_valid: got %b expected 1", out_valid); end
        drain();
    endtask

`ifdef DESER_FLUSH_EN
    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
        feed(1'b1);
        feed(1'b1);
        flush = 1'b1;
        step();
        checks++; if (out_data !== 4'b0011) begin errors++; $display("FAIL flush_data: got %b expected 0011", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
        step();
        flush = 1'b0;
        checks++; if (out_data !== 4'b0011) begin errors++; $display("FAIL flush_in_hold: got %b expected 0011", out_data); end
        drain();
        flush = 1'b1;
        feed(1'b1);
        flush = 1'b0;
        checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL flush_with_accept: got %b expected 0001", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_with_accept_valid: got %b expected 1", out_valid); end
        drain();
        feed(1'b1);
        checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL flush_idx_reset: got %b expected 0001", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idx_reset_valid: got %b expected 0", out_valid); end
    endtask
`endif

    task automatic test_wide();
        logic [15:0] word;
        word = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            w_bit   = word[i];
            w_valid = 1'b1;
            step();
            if (i == 14) begin
                checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wide_early_valid: got %b expected 0", w_out_valid); end
            end
        end
        w_valid = 1'b0;
        checks++; if (w_data !== 16'hA5C3) begin errors++; $display("FAIL wide_data: got %h expected a5c3", w_data); end
        checks++; if (w_out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid: got %b expected 1", w_out_valid); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL wide_ready: got %b expected 0", w_ready); end
    endtask

    initial begin
        reset       = 1'b1;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        w_bit       = 1'b0;
        w_valid     = 1'b0;
        w_out_ready = 1'b0;
        #12;
        reset = 1'b0;
        step();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold();
        test_mid_reset();
`ifdef DESER_FLUSH_EN
        test_flush();
`endif
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
